// File: rtl/zbuf_writer.sv
// Depth-test and pixel-write stage: keeps the nearest sample per pixel of the 320x65 view.
// Define ZBUF_STATS_EN to build the pass/drop counters; otherwise both read as constant 0.
module zbuf_writer #(
  parameter int                         DATA_W   = 10,
  parameter int                         WIDTH    = 320,
  parameter int                         HEIGHT   = 65,
  parameter logic signed [DATA_W-1:0]   ZMAX     = 10'sd511,
  parameter logic        [DATA_W-1:0]   BG_COLOR = 10'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic signed [DATA_W-1:0] in_z,
  input  logic signed [DATA_W-1:0] in_p,
  output logic                     busy,
  output logic                     fb_we,
  output logic [14:0]              fb_addr,
  output logic [DATA_W-1:0]        fb_data,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int ADDR_W = 15;
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                    state, state_nx;
  logic [ADDR_W-1:0]         clr_addr, clr_addr_nx;

  logic                      in_range, accept;
  logic [ADDR_W-1:0]         addr_s0;

  logic                      vld_p0, vld_p1, vld_p2;
  logic [ADDR_W-1:0]         addr_p0, addr_p1, addr_p2;
  logic signed [DATA_W-1:0]  z_p0, z_p1, z_p2;
  logic signed [DATA_W-1:0]  pix_p0, pix_p1, pix_p2;
  logic signed [DATA_W-1:0]  zold_s1, zold_p2;
  logic signed [DATA_W-1:0]  ram_q;
  logic signed [DATA_W-1:0]  zram [DEPTH];

  logic                      z_win, pass_s2;
  logic                      clear_wr, s2_wr;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_waddr;
  logic signed [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]         fb_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    case (state)
      CLEAR: begin
        if (frame_start) begin
          clr_addr_nx = '0;
        end else if (clr_addr == LAST_ADDR) begin
          state_nx    = RUN;
          clr_addr_nx = '0;
        end else begin
          clr_addr_nx = clr_addr + 1'b1;
        end
      end
      RUN: begin
        if (frame_start) begin
          state_nx    = CLEAR;
          clr_addr_nx = '0;
        end
      end
      default: begin
        state_nx    = CLEAR;
        clr_addr_nx = '0;
      end
    endcase
  end

  // frame_start suppresses every write in the cycle it arrives, which is how the flush drops S2
  always_comb begin
    busy      = (state == CLEAR);
    clear_wr  = (state == CLEAR) && !frame_start;
    s2_wr     = (state == RUN) && !frame_start && pass_s2;
    ram_we    = clear_wr || s2_wr;
    ram_waddr = clear_wr ? clr_addr : addr_p2;
    ram_wdata = clear_wr ? ZMAX : z_p2;
    fb_data_d = clear_wr ? BG_COLOR : unsigned'(pix_p2);
  end

  // ---- S0: bounds check, address generation ----
  always_comb begin
    in_range = !in_x[DATA_W-1] && (int'(in_x) < WIDTH) &&
               !in_y[DATA_W-1] && (int'(in_y) < HEIGHT) &&
               !in_z[DATA_W-1];
    accept   = (state == RUN) && en && !frame_start;
    addr_s0  = ADDR_W'(unsigned'(in_y)) * ADDR_W'(WIDTH) + ADDR_W'(unsigned'(in_x));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || frame_start) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= accept && in_range;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    addr_p0 <= addr_s0;
    z_p0    <= in_z;
    pix_p0  <= in_p;
    addr_p1 <= addr_p0;
    z_p1    <= z_p0;
    pix_p1  <= pix_p0;
    addr_p2 <= addr_p1;
    z_p2    <= z_p1;
    pix_p2  <= pix_p1;
    zold_p2 <= zold_s1;
  end

  // A read landing on the same edge as a write to that address returns the new depth;
  // this covers the sample two behind a writer, which the S1 forward can no longer see.
  always_ff @(posedge clk) begin
    if (ram_we) zram[ram_waddr] <= ram_wdata;
    if (vld_p0) ram_q <= (ram_we && ram_waddr == addr_p0) ? ram_wdata : zram[addr_p0];
  end

  // ---- S1: depth returned, forward from an S2 write to the same pixel ----
  always_comb begin
    zold_s1 = (s2_wr && addr_p2 == addr_p1) ? z_p2 : ram_q;
  end

  // ---- S2: strict compare, equal depth keeps the earlier sample ----
  always_comb begin
    z_win   = z_p2 < zold_p2;
    pass_s2 = vld_p2 && z_win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= ram_we;
      if (ram_we) begin
        fb_addr <= ram_waddr;
        fb_data <= fb_data_d;
      end
    end
  end

`ifdef ZBUF_STATS_EN
  logic [1:0] drop_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // an out-of-range S0 sample and a depth-fail in S2 can land on the same edge
  always_comb begin
    drop_inc = 2'd0;
    if (state == CLEAR) drop_inc = {1'b0, en};
    else                drop_inc = 2'(accept && !in_range) + 2'(vld_p2 && !z_win);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || frame_start) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pass_cnt <= sat_inc(pass_cnt, {1'b0, s2_wr});
      drop_cnt <= sat_inc(drop_cnt, drop_inc);
    end
  end
`else
  assign pass_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_zbuf_writer.sv
// Directed bench for zbuf_writer: scoreboard of expected frame-buffer writes plus counter checks.
module tb_zbuf_writer;

`ifdef ZBUF_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  localparam int NPIX = 320 * 65;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              en = 1'b0;
  logic signed [9:0] in_x = '0, in_y = '0, in_z = '0, in_p = '0;
  logic              busy, fb_we;
  logic [14:0]       fb_addr;
  logic [9:0]        fb_data;
  logic [15:0]       pass_cnt, drop_cnt;

  typedef struct packed {
    logic [14:0] addr;
    logic [9:0]  data;
  } wr_t;

  wr_t sb[$];
  int  compared = 0;
  int  mismatched = 0;
  int  we_cnt = 0;
  int  n = 0;
  bit  mon_en = 1'b0;

  zbuf_writer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .en(en),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_p(in_p),
    .busy(busy), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    en = 1'b0;
    repeat (cycles) step();
  endtask

  task automatic sample(input int x, input int y, input int z, input int p);
    en   = 1'b1;
    in_x = 10'(x);
    in_y = 10'(y);
    in_z = 10'(z);
    in_p = 10'(p);
    step();
  endtask

  task automatic push_wr(input int a, input int d);
    sb.push_back('{addr: 15'(a), data: 10'(d)});
  endtask

  task automatic push_clear();
    for (int i = 0; i < NPIX; i++) push_wr(i, 0);
  endtask

  task automatic wait_clear(output int cycles);
    cycles = 0;
    while (busy && cycles < NPIX + 100) begin
      cycles++;
      step();
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (mon_en && fb_we === 1'b1) begin
      we_cnt++;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(e.addr));
        chk("wr_data", 32'(fb_data), 32'(e.data));
      end
    end
  end

  initial begin
    // power-on reset and full clear
    step();
    step();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_data", 32'(fb_data), 0);
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    push_clear();
    mon_en = 1'b1;
    we_cnt = 0;
    rst_n  = 1'b1;
    wait_clear(n);
    chk("clear_busy_cycles", 32'(n), 32'(NPIX));
    chk("clear_busy_low", 32'(busy), 0);
    step();
    step();
    chk("clear_we_cnt", 32'(we_cnt), 32'(NPIX));
    chk("clear_drained", 32'(sb.size()), 0);

    // single sample, exact latency and one-cycle strobe
    push_wr(650, 7);
    sample(10, 2, 100, 7);
    en = 1'b0;
    step();
    step();
    chk("lat_early", 32'(fb_we), 0);
    step();
    chk("lat_we", 32'(fb_we), 1);
    chk("lat_addr", 32'(fb_addr), 650);
    chk("lat_data", 32'(fb_data), 7);
    step();
    chk("we_pulse", 32'(fb_we), 0);
    chk("single_pass", 32'(pass_cnt), 32'(STATS * 1));
    chk("single_drop", 32'(drop_cnt), 0);

    // back-to-back samples on one pixel: 200 and 150 win, equal 150 and 300 lose
    push_wr(1605, 1);
    push_wr(1605, 2);
    sample(5, 5, 200, 1);
    sample(5, 5, 150, 2);
    sample(5, 5, 150, 3);
    sample(5, 5, 300, 4);
    idle(6);
    chk("order_drained", 32'(sb.size()), 0);
    chk("order_drop", 32'(drop_cnt), 32'(STATS * 2));
    chk("order_pass", 32'(pass_cnt), 32'(STATS * 3));

    // bounds: four rejects, then the last pixel at z=0 is accepted
    push_wr(20799, 5);
    sample(320, 0, 10, 9);
    sample(0, 65, 10, 9);
    sample(-1, 0, 10, 9);
    sample(0, 0, -3, 9);
    sample(319, 64, 0, 5);
    idle(6);
    chk("bounds_drained", 32'(sb.size()), 0);
    chk("bounds_drop", 32'(drop_cnt), 32'(STATS * 6));
    chk("bounds_pass", 32'(pass_cnt), 32'(STATS * 4));

    // abort: in-flight sample and a sample coincident with frame_start both vanish
    sample(1, 1, 50, 3);
    frame_start = 1'b1;
    en   = 1'b1;
    in_x = 10'sd2;
    in_y = 10'sd2;
    step();
    frame_start = 1'b0;
    en = 1'b0;
    push_clear();
    chk("abort_busy", 32'(busy), 1);
    chk("abort_pass", 32'(pass_cnt), 0);
    chk("abort_drop", 32'(drop_cnt), 0);

    // ten samples during the clear are dropped and counted
    for (int i = 0; i < 10; i++) begin
      sample(20 + i, 3, 5, 1);
      idle(1);
    end
    wait_clear(n);
    chk("clr_samples_busy_low", 32'(busy), 0);
    chk("clr_samples_drop", 32'(drop_cnt), 32'(STATS * 10));
    chk("clr_samples_pass", 32'(pass_cnt), 0);
    step();
    step();
    chk("abort_drained", 32'(sb.size()), 0);

    // depth buffer was really cleared: z=400 beats 511 where 100 used to be
    push_wr(650, 8);
    sample(10, 2, 400, 8);
    idle(5);
    chk("reclear_drained", 32'(sb.size()), 0);
    chk("reclear_pass", 32'(pass_cnt), 32'(STATS * 1));

    // reset mid-operation discards the in-flight sample and restarts the clear
    sample(3, 3, 20, 1);
    rst_n = 1'b0;
    en    = 1'b0;
    step();
    step();
    chk("mrst_busy", 32'(busy), 1);
    chk("mrst_fb_we", 32'(fb_we), 0);
    chk("mrst_fb_addr", 32'(fb_addr), 0);
    chk("mrst_pass", 32'(pass_cnt), 0);
    chk("mrst_drop", 32'(drop_cnt), 0);
    push_clear();
    we_cnt = 0;
    rst_n  = 1'b1;
    wait_clear(n);
    chk("mrst_busy_cycles", 32'(n), 32'(NPIX));
    step();
    step();
    chk("mrst_we_cnt", 32'(we_cnt), 32'(NPIX));
    chk("mrst_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/zbuf_writer.md
# zbuf_writer

Depth-test and pixel-write stage directly downstream of the wall visibility check. It consumes the per-sample stream (`en`, x, y, z, p), holds a private depth buffer covering the 320×65 maze view, and keeps the nearest sample per pixel. Winning samples are forwarded to the frame buffer as write strobes. On every frame start it clears the depth buffer and paints the frame buffer with the background colour.

## Interface
- `WIDTH`, 320, view columns (5 walls × 64)
- `HEIGHT`, 65, view rows (y = 0..64 inclusive)
- `ZMAX`, 10'sd511, depth written on clear (farthest)
- `BG_COLOR`, 10'd0, pixel value written to the frame buffer on clear
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `frame_start` in 1: single-cycle pulse that starts a buffer clear
- `en` in 1: sample valid (from the visibility check)
- `in_x` in 10 signed: column
- `in_y` in 10 signed: row
- `in_z` in 10 signed: depth, smaller is nearer
- `in_p` in 10 signed: pixel value
- `busy` out 1: clear in progress; samples are dropped
- `fb_we` out 1: frame-buffer write strobe
- `fb_addr` out 15: frame-buffer address, y*WIDTH + x
- `fb_data` out 10: frame-buffer pixel
- `pass_cnt` out 16: samples that won the depth test since the last clear
- `drop_cnt` out 16: samples discarded since the last clear

## Operation
- **FSM states:** CLEAR, RUN.
  - Reset puts the FSM in CLEAR with the clear address at 0.
- **CLEAR:** one address per cycle, 0..WIDTH*HEIGHT−1 (20799).
  - Each cycle writes ZMAX to the depth RAM.
  - Each cycle asserts `fb_we` with `fb_addr` equal to the clear address and `fb_data` = BG_COLOR.
  - After address 20799 is written, the FSM moves to RUN and `busy` falls on the next cycle.
- **RUN: 3-stage pipeline.**
  - **S0:** when `en`=1, compute addr = in_y*WIDTH + in_x (unsigned 15-bit) and issue the RAM read.
    - Drop the sample if in_x<0, in_x≥WIDTH, in_y<0, in_y≥HEIGHT or in_z<0.
    - `en`=0 inserts a bubble.
  - **S1:** RAM data returns.
    - Forwarding: if S2 is writing the same address this cycle, use the S2 write data in place of RAM data.
    - Back-to-back samples to one pixel therefore always compare against the latest depth.
  - **S2:** signed compare; the sample passes when in_z < stored z.
    - Equal depth fails: the first-drawn sample wins.
    - On pass: write in_z to the depth RAM, and assert `fb_we`, `fb_addr`=addr, `fb_data`=in_p, all registered.
- **Counters:** `pass_cnt` increments per pass.
  - `drop_cnt` increments per out-of-range sample, per depth-fail, and per `en`=1 sample during CLEAR.
  - Both saturate at 16'hFFFF and reset to 0 at clear start.
- **`frame_start`:**
  - In RUN: flush S0–S2 (no writes, no counts) and enter CLEAR at address 0 next cycle.
  - In CLEAR: restart the clear from address 0.
- **Simultaneous `frame_start` and `en`:** the sample is dropped and not counted.

## Timing
- **Reset values:** `busy`=1, `fb_we`=0, `fb_addr`=0, `fb_data`=0, `pass_cnt`=0, `drop_cnt`=0; FSM=CLEAR.
- **Reset mid-operation:** identical to power-on reset, including discarding in-flight samples.
- **Clear duration:** WIDTH*HEIGHT cycles of `fb_we`=1 (20800 with default parameters).
- **RUN latency:** `en` sampled at edge t; if the sample passes, `fb_we`=1 is visible after edge t+3.
- **Throughput:** one sample per cycle, no backpressure, no stalls.
- **`fb_we`:** high for exactly one cycle per write.
- **Depth RAM:** 20800×10, single synchronous read port and single write port.
- **Write priority:** a depth RAM write in S2 takes effect before any later S0 read of the same address, via the forwarding path.

## Configuration
- Macro: `ZBUF_STATS_EN`.
- **Defined:** `pass_cnt` and `drop_cnt` are implemented as described.
- **Undefined:** counter logic is removed and both outputs are constant 0.
  - Pipeline and `fb_*` behaviour are identical in both builds.

## Test plan
- **Reset clear:** assert `rst_n`=0 for 2 cycles, then release.
  - `busy`=1 for exactly 20800 cycles.
  - `fb_we` high every one of those cycles, `fb_addr` 0→20799, `fb_data`=0.
  - Then `busy`=0.
- **Single sample:** in RUN, sample x=10, y=2, z=100, p=7.
  - Three cycles later: `fb_we`=1, `fb_addr`=650, `fb_data`=7.
  - With `ZBUF_STATS_EN`: `pass_cnt`=1.
- **Depth order on one pixel:** back-to-back samples at (5,5) with z=200 p=1, then z=150 p=2, then z=150 p=3, then z=300 p=4.
  - Exactly two writes: p=1, then p=2 (exercises forwarding).
  - `drop_cnt`=2.
- **Bounds:** samples x=320; y=65; x=−1; z=−3.
  - No `fb_we`.
  - `drop_cnt`=4.
- **Abort:** pulse `frame_start` one cycle after a valid sample.
  - No write from that sample.
  - `busy` rises, and the clear restarts at `fb_addr`=0.
  - Counters read 0.
- **Samples during clear:** `en`=1 during CLEAR at 10 different cycles.
  - No sample writes.
  - `drop_cnt`=10 when `busy` falls.
